lift_seq_ctrl: RTL and testbench

LIFT_SEQ_CTRL -- requirements
Module: lift_seq_ctrl

---
 rtl/lift_pkg.sv | 28 ++
 rtl/lift_seq_cnt.sv | 41 ++++
 rtl/lift_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_lift_seq_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared sizing, stroke encodings and sequencer states for the lifting column sequencer.
package lift_pkg;

    localparam int NSAMP = 16;
    localparam int W     = 9;
    localparam int CW    = 9;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_PRED = 2'b01;
    localparam logic [1:0] SEL_UPD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRED,
        PWAIT,
        UPD,
        UWAIT,
        OUT,
        DONE
    } lift_state_e;

    // The first stroke of a column is predict unless the order is reversed.
    function automatic logic [1:0] stroke_sel(input logic second, input logic rev);
        return (second ^ rev) ? SEL_UPD : SEL_PRED;
    endfunction

endpackage

// File: rtl/lift_seq_cnt.sv
// Column counter for lift_seq_ctrl: holds the latched column count and flags the last column.
module lift_seq_cnt
    import lift_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          clr_i,
    input  logic [CW-1:0] ncols_i,
    input  logic          inc_i,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    logic [CW-1:0] ncols_q, ncols_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        ncols_d = ncols_q;
        col_d   = col_q;
        if (clr_i) begin
            ncols_d = ncols_i;
            col_d   = '0;
        end else if (inc_i) begin
            col_d = col_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ncols_q <= '0;
            col_q   <= '0;
        end else begin
            ncols_q <= ncols_d;
            col_q   <= col_d;
        end
    end

    assign col_o  = col_q;
    assign last_o = (col_q == (ncols_q - CW'(1)));

endmodule

// File: rtl/lift_seq_ctrl.sv
// Frame sequencer for the lifting datapath: loads a column, issues two strokes, hands the result out.
// Define LIFT_SEQ_INV_EN to add the inv port, which selects update-then-predict stroke order.
module lift_seq_ctrl
    import lift_pkg::*;
#(
    parameter int NSAMP = lift_pkg::NSAMP,
    parameter int W     = lift_pkg::W
) (
    input  logic               clock,
    input  logic               reset,
`ifdef LIFT_SEQ_INV_EN
    input  logic               inv,
`endif
    input  logic               start,
    input  logic [CW-1:0]      ncols,
    input  logic [NSAMP*W-1:0] flati,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NSAMP*W-1:0] dp_flats,
    output logic               lift_en,
    output logic [1:0]         lift_sel,
    input  logic [NSAMP*W-1:0] dp_result,
    input  logic               dp_valid,
    output logic [NSAMP*W-1:0] flato,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      gflt_col,
    output logic               busy,
    output logic               done
);

    localparam int VW = NSAMP * W;

    lift_state_e   state_q, state_d;
    logic [VW-1:0] work_q, work_d;
    logic          cnt_clr, cnt_inc, cnt_last;
    logic          rev;

`ifdef LIFT_SEQ_INV_EN
    logic inv_q, inv_d;

    assign inv_d = (state_q == IDLE && start) ? inv : inv_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) inv_q <= 1'b0;
        else       inv_q <= inv_d;
    end

    assign rev = inv_q;
`else
    assign rev = 1'b0;
`endif

    lift_seq_cnt u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .ncols_i (ncols),
        .inc_i   (cnt_inc),
        .col_o   (gflt_col),
        .last_o  (cnt_last)
    );

    // Outputs decode straight from state so an async reset clears them in the same cycle.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lift_en   = 1'b0;
        lift_sel  = SEL_NONE;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (ncols == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = flati;
                    state_d = PRED;
                end
            end
            PRED: begin
                lift_en  = 1'b1;
                lift_sel = stroke_sel(1'b0, rev);
                state_d  = PWAIT;
            end
            PWAIT: begin
                if (dp_valid) begin
                    work_d  = dp_result;
                    state_d = UPD;
                end
            end
            UPD: begin
                lift_en  = 1'b1;
                lift_sel = stroke_sel(1'b1, rev);
                state_d  = UWAIT;
            end
            UWAIT: begin
                if (dp_valid) begin
                    work_d  = dp_result;
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
        end
    end

    assign dp_flats = work_q;
    assign flato    = work_q;

endmodule

// File: tb/tb_lift_seq_ctrl.sv
// Self-checking bench for lift_seq_ctrl: a column-level model predicts strokes, outputs and indices.
// Build with LIFT_SEQ_INV_EN defined to also exercise the reversed stroke order.
module tb_lift_seq_ctrl;

    localparam int VW = 144;
    localparam logic [VW-1:0] ALL1 = {VW{1'b1}};
    localparam logic [VW-1:0] KP   = {16{9'h0a5}};
    localparam logic [VW-1:0] KU   = 144'h0003_0000_0000_1234_5678_9abc_def0_0001;
    localparam logic [VW-1:0] V34  = 144'h1ffc0000000000000001c0000000000001ff;
    localparam logic [VW-1:0] VA   = 144'h0123_4567_89ab_cdef_0011_2233_4455_6677_8899;
    localparam logic [VW-1:0] VB   = {16{9'h13c}};

    logic          clock, reset, start;
    logic [8:0]    ncols;
    logic [VW-1:0] flati, dp_flats, dp_result, flato;
    logic          in_valid, in_ready, lift_en, dp_valid, out_valid, out_ready, busy, done;
    logic [1:0]    lift_sel;
    logic [8:0]    gflt_col;
`ifdef LIFT_SEQ_INV_EN
    logic          inv;
`endif

    lift_seq_ctrl dut (
        .clock     (clock),
        .reset     (reset),
`ifdef LIFT_SEQ_INV_EN
        .inv       (inv),
`endif
        .start     (start),
        .ncols     (ncols),
        .flati     (flati),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dp_flats  (dp_flats),
        .lift_en   (lift_en),
        .lift_sel  (lift_sel),
        .dp_result (dp_result),
        .dp_valid  (dp_valid),
        .flato     (flato),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gflt_col  (gflt_col),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int nChecks, nPass, cyc;
    int dpDelay, dpCount, stallCol, stallLeft, frameCols, outCount, doneCount, strokeIdx;
    bit xorMode, invQ, srcEnable, srcFire, spurArm, prevHold, frameOn;
    logic [VW-1:0] dpRes, prevFlato;
    logic [VW-1:0] srcQ[$], expQ[$], selLog[$], colLog[$], outLog[$];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [VW-1:0] qAt(input logic [VW-1:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // Column result as the spec defines it: predict then update, or reversed.
    function automatic logic [VW-1:0] modelOut(input logic [VW-1:0] x);
        if (xorMode) return (x ^ ALL1) ^ ALL1;
        if (invQ)    return (x + KU) ^ KP;
        return (x ^ KP) + KU;
    endfunction

    function automatic logic [VW-1:0] stubDp(input logic [VW-1:0] x, input logic [1:0] sel);
        if (xorMode) return x ^ ALL1;
        case (sel)
            2'b01:   return x ^ KP;
            2'b10:   return x + KU;
            default: return ALL1;
        endcase
    endfunction

    // One clock: compare outputs, then act as datapath, column source and sink.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (reset) begin
            srcQ.delete();
            expQ.delete();
            in_valid  = 1'b0;
            flati     = '0;
            dp_valid  = 1'b0;
            dpCount   = 0;
            srcFire   = 1'b0;
            out_ready = 1'b1;
            prevHold  = 1'b0;
            frameOn   = 1'b0;
            spurArm   = 1'b0;
            return;
        end
        if (!lift_en) chk("sel_none", VW'(lift_sel), '0);
        if (!busy) chk("idle_quiet", VW'({in_ready, out_valid, lift_en, done}), '0);
        if (lift_en) begin
            chk("stroke_sel", VW'(lift_sel), VW'(((strokeIdx == 0) != invQ) ? 2'b01 : 2'b10));
            selLog.push_back(VW'(lift_sel));
            strokeIdx++;
        end
        if (prevHold) begin
            chk("hold_valid", VW'(out_valid), VW'(1));
            chk("hold_flato", flato, prevFlato);
        end
        if (out_valid) begin
            if (expQ.size() == 0) chk("flato_extra", VW'(out_valid), '0);
            else chk("flato", flato, expQ[0]);
        end
        if (busy && frameOn && frameCols != 0)
            chk("gflt_col", VW'(gflt_col), VW'((outCount < frameCols) ? outCount : frameCols - 1));
        if (done) begin
            chk("done_cols", VW'(outCount), VW'(frameCols));
            chk("done_left", VW'(expQ.size()), '0);
            doneCount++;
            frameOn = 1'b0;
        end

        dp_valid = 1'b0;
        if (dpCount > 0) begin
            dpCount--;
            if (dpCount == 0) begin
                dp_valid  = 1'b1;
                dp_result = dpRes;
            end
        end
        if (lift_en) begin
            dpRes   = stubDp(dp_flats, lift_sel);
            dpCount = dpDelay;
        end
        if (spurArm && in_ready && !dp_valid) begin
            dp_valid  = 1'b1;
            dp_result = ~dp_flats ^ KU;
            spurArm   = 1'b0;
        end

        if (srcFire) begin
            void'(srcQ.pop_front());
            srcFire = 1'b0;
        end
        in_valid = srcEnable && (srcQ.size() > 0);
        flati    = in_valid ? srcQ[0] : '0;
        if (in_valid && in_ready) begin
            srcFire = 1'b1;
            expQ.push_back(modelOut(srcQ[0]));
            strokeIdx = 0;
        end

        out_ready = 1'b1;
        if (out_valid && outCount == stallCol && stallLeft > 0) begin
            out_ready = 1'b0;
            stallLeft--;
        end
        prevHold  = out_valid && !out_ready;
        prevFlato = flato;
        if (out_valid && out_ready) begin
            colLog.push_back(VW'(gflt_col));
            outLog.push_back(flato);
            if (expQ.size() > 0) void'(expQ.pop_front());
            outCount++;
        end
    endtask

    task automatic pulseStart(input logic [8:0] n, input bit invv);
        tick();
        selLog.delete();
        colLog.delete();
        outLog.delete();
        frameCols = int'(n);
        outCount  = 0;
        invQ      = invv;
        frameOn   = 1'b1;
        start     = 1'b1;
        ncols     = n;
`ifdef LIFT_SEQ_INV_EN
        inv       = invv;
`endif
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", VW'(done), VW'(1));
    endtask

    task automatic waitLiftEn(input int count, input int bound);
        int k = 0;
        int n = 0;
        while (k < count && n < bound) begin
            tick();
            n++;
            if (lift_en) k++;
        end
        chk("lift_en_seen", VW'(k), VW'(count));
    endtask

    initial begin
        int n, d0;
        nChecks = 0; nPass = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; ncols = '0;
        in_valid = 1'b0; flati = '0; dp_valid = 1'b0; dp_result = '0; out_ready = 1'b1;
`ifdef LIFT_SEQ_INV_EN
        inv = 1'b0;
`endif
        xorMode = 1'b0; invQ = 1'b0; dpDelay = 1; srcEnable = 1'b1;
        stallCol = -1; stallLeft = 0; spurArm = 1'b0; srcFire = 1'b0; dpCount = 0;
        prevHold = 1'b0; frameOn = 1'b0; frameCols = 0; outCount = 0; doneCount = 0; strokeIdx = 0;
        dpRes = '0; prevFlato = '0;

        #1;
        chk("rst_busy", VW'(busy), '0);
        chk("rst_ctl", VW'({in_ready, out_valid, lift_en, done, lift_sel}), '0);
        chk("rst_col", VW'(gflt_col), '0);
        chk("rst_flato", flato, '0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single column, self-inverting datapath, everything always ready.
        xorMode = 1'b1;
        srcQ.push_back(V34);
        pulseStart(9'd1, 1'b0);
        chk("load_ready", VW'(in_ready), VW'(1));
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("latency", VW'(n), VW'(6));
        chk("sel_first", qAt(selLog, 0), VW'(2'b01));
        chk("sel_second", qAt(selLog, 1), VW'(2'b10));
        chk("sel_count", VW'(selLog.size()), VW'(2));
        chk("flato_pin", qAt(outLog, 0), V34);

        // Three columns with a four-cycle output stall on column 1.
        xorMode = 1'b0;
        stallCol = 1;
        stallLeft = 4;
        srcQ.push_back(KP);
        srcQ.push_back(VA);
        srcQ.push_back(VB);
        d0 = doneCount;
        pulseStart(9'd3, 1'b0);
        waitDone(200);
        repeat (3) tick();
        chk("stall_used", VW'(stallLeft), '0);
        chk("col_seq0", qAt(colLog, 0), VW'(0));
        chk("col_seq1", qAt(colLog, 1), VW'(1));
        chk("col_seq2", qAt(colLog, 2), VW'(2));
        chk("fwd_pin", qAt(outLog, 0), KU);
        chk("one_done", VW'(doneCount - d0), VW'(1));
        stallCol = -1;

        // Empty frame: straight to a done pulse.
        d0 = doneCount;
        pulseStart(9'd0, 1'b0);
        chk("z_done", VW'(done), VW'(1));
        chk("z_busy", VW'(busy), VW'(1));
        chk("z_ready", VW'(in_ready), '0);
        tick();
        chk("z_busy_off", VW'(busy), '0);
        chk("z_done_off", VW'(done), '0);
        chk("z_one_done", VW'(doneCount - d0), VW'(1));

        // Reset while column 2 of 4 waits on its update result.
        dpDelay = 3;
        srcQ.push_back(VA);
        srcQ.push_back(VB);
        srcQ.push_back(KP);
        srcQ.push_back(V34);
        pulseStart(9'd4, 1'b0);
        waitLiftEn(6, 300);
        tick();
        chk("pre_rst_col", VW'(gflt_col), VW'(2));
        #2 reset = 1'b1;
        #1;
        chk("mr_busy", VW'(busy), '0);
        chk("mr_ctl", VW'({in_ready, out_valid, lift_en, done}), '0);
        chk("mr_sel", VW'(lift_sel), '0);
        chk("mr_col", VW'(gflt_col), '0);
        chk("mr_flato", flato, '0);
        chk("mr_work", dp_flats, '0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", VW'(busy), '0);
        dpDelay = 1;
        srcQ.push_back(VB);
        srcQ.push_back(VA);
        d0 = doneCount;
        pulseStart(9'd2, 1'b0);
        chk("restart_col", VW'(gflt_col), '0);
        waitDone(200);
        chk("restart_outs", VW'(outLog.size()), VW'(2));
        chk("restart_done", VW'(doneCount - d0), VW'(1));

        // Spurious dp_valid in LOAD and a start re-pulse in PWAIT are both ignored.
        dpDelay = 3;
        srcEnable = 1'b0;
        srcQ.push_back(KP);
        srcQ.push_back(VB);
        d0 = doneCount;
        pulseStart(9'd2, 1'b0);
        tick();
        spurArm = 1'b1;
        tick();
        tick();
        chk("spur_load_held", VW'(in_ready), VW'(1));
        srcEnable = 1'b1;
        waitLiftEn(1, 50);
        tick();
        start = 1'b1;
        ncols = 9'd0;
        tick();
        start = 1'b0;
        waitDone(300);
        chk("ign_outs", VW'(outLog.size()), VW'(2));
        chk("ign_pin", qAt(outLog, 0), KU);
        chk("ign_col1", qAt(colLog, 1), VW'(1));
        chk("ign_done", VW'(doneCount - d0), VW'(1));
        dpDelay = 1;

`ifdef LIFT_SEQ_INV_EN
        // Reversed order: update then predict.
        srcQ.push_back('0 - KU);
        pulseStart(9'd1, 1'b1);
        waitDone(100);
        chk("inv_sel_first", qAt(selLog, 0), VW'(2'b10));
        chk("inv_sel_second", qAt(selLog, 1), VW'(2'b01));
        chk("inv_pin", qAt(outLog, 0), KP);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
